// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
//   Digit-serial packed-BCD adder. Operand digits are processed one per clock,
//   least significant first. Each digit goes through a single 4-bit binary add
//   followed by a +6 decimal correction. The decimal carry is registered
//   between digits.
//
//   Operands are taken over an in_valid/in_ready handshake. The packed BCD sum
//   and decimal carry-out are returned over an out_valid/out_ready handshake.
//
// Optional feature:
//   BCD_ERR_EN  when defined, adds the err output. err flags any operand digit
//               greater than 9 seen during the operation. It is valid together
//               with out_valid.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   a, b and cin are valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       packed BCD operands, digit 0 in [3:0]
//   cin        decimal carry-in
//   out_valid  sum and cout are valid (DONE)
//   out_ready  consumer accepts the result
//   sum        packed BCD result
//   cout       decimal carry-out
//   err        non-BCD input digit seen (BCD_ERR_EN only)

module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
`ifdef BCD_ERR_EN
    output logic                  cout,
    output logic                  err
`else
    output logic                  cout
`endif
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [IDXW-1:0]     idx;
    logic [4*DIGITS-1:0] a_reg;
    logic [4*DIGITS-1:0] b_reg;
    logic                c;

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [4:0] t;
    logic [4:0] t_adj;
    logic       dig_carry;
    logic [3:0] dig;

    // Both handshake outputs come from state (and rst), never from
    // in_valid or out_ready.
    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);

    // One digit of decimal addition. Any sum above 9 is corrected by adding 6,
    // which wraps the low nibble back into 0..9 for legal BCD inputs.
    // Non-BCD digits follow the same rule modulo 16.
    always_comb begin
        a_dig     = a_reg[{idx, 2'b00} +: 4];
        b_dig     = b_reg[{idx, 2'b00} +: 4];
        t         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, c};
        t_adj     = t + 5'd6;
        dig_carry = (t > 5'd9);
        dig       = dig_carry ? t_adj[3:0] : t[3:0];
    end

    // Control and datapath sequencing: IDLE latches operands, RUN writes one
    // sum digit per cycle, and DONE holds the result until the consumer
    // takes it. Operand registers only load in IDLE, so in_valid pulses
    // during RUN/DONE have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            c     <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        c     <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= dig;
                    c <= dig_carry;
                    if (idx == LAST_IDX) begin
                        cout  <= dig_carry;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCD_ERR_EN
    // Sticky non-BCD flag. It is cleared when new operands are accepted and
    // set by any digit above 9 processed in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            err <= 1'b0;
        end else if (state == RUN && (a_dig > 4'd9 || b_dig > 4'd9)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder
//   Directed testbench for bcd_serial_adder with DIGITS=4. Every expected
//   sum was computed by hand, digit by digit, using the +6 correction rule.
//   Build with BCD_ERR_EN defined to also exercise the err output.

module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef BCD_ERR_EN
    logic        err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef BCD_ERR_EN
        .cout      (cout),
        .err       (err)
`else
        .cout      (cout)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one operation for a single
    // accept edge, then counts edges until out_valid rises (bounded).
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        logic seen;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'h0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
`ifdef BCD_ERR_EN
        checkOutput("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic add, latency and single-cycle DONE with out_ready high
        applyStimulus(16'h1234, 16'h5678, 1'b0, lat);
        checkOutput("lat_1234", 32'(lat), 32'd4);
        checkOutput("sum_1234", 32'(sum), 32'h6912);
        checkOutput("cout_1234", 32'(cout), 32'd0);
        @(posedge clk); #1;
        checkOutput("done_1cyc_ov", 32'(out_valid), 32'd0);
        checkOutput("done_1cyc_ir", 32'(in_ready), 32'd1);
        checkOutput("held_1234", 32'(sum), 32'h6912);

        // Carry ripples through every digit
        applyStimulus(16'h9999, 16'h0001, 1'b0, lat);
        checkOutput("sum_ripple", 32'(sum), 32'h0000);
        checkOutput("cout_ripple", 32'(cout), 32'd1);
        @(posedge clk); #1;

        // Maximum operands with carry-in
        applyStimulus(16'h9999, 16'h9999, 1'b1, lat);
        checkOutput("lat_max", 32'(lat), 32'd4);
        checkOutput("sum_max", 32'(sum), 32'h9999);
        checkOutput("cout_max", 32'(cout), 32'd1);
        @(posedge clk); #1;

        // Carry-in alone
        applyStimulus(16'h0000, 16'h0000, 1'b1, lat);
        checkOutput("sum_cin", 32'(sum), 32'h0001);
        checkOutput("cout_cin", 32'(cout), 32'd0);
        @(posedge clk); #1;

        // Backpressure: result holds for 5 cycles, stray in_valid ignored
        out_ready = 1'b0;
        applyStimulus(16'h5678, 16'h4444, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a = 16'h1111; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            checkOutput("bp_sum", 32'(sum), 32'h0122);
            checkOutput("bp_cout", 32'(cout), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_rel_ov", 32'(out_valid), 32'd0);
        checkOutput("bp_rel_ir", 32'(in_ready), 32'd1);
        checkOutput("bp_rel_sum", 32'(sum), 32'h0122);
        @(posedge clk); #1;
        checkOutput("bp_no_pending", 32'(in_ready), 32'd1);

        // Non-BCD digit: mod-16 rule, A+0 -> 0 with carry
        applyStimulus(16'h00A0, 16'h0000, 1'b0, lat);
        checkOutput("sum_nonbcd", 32'(sum), 32'h0100);
        checkOutput("cout_nonbcd", 32'(cout), 32'd0);
`ifdef BCD_ERR_EN
        checkOutput("err_set", 32'(err), 32'd1);
`endif
        @(posedge clk); #1;
        applyStimulus(16'h0001, 16'h0001, 1'b0, lat);
        checkOutput("sum_after_err", 32'(sum), 32'h0002);
`ifdef BCD_ERR_EN
        checkOutput("err_clear", 32'(err), 32'd0);
`endif
        @(posedge clk); #1;

        // Reset during the second RUN cycle
        a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("partial_sum", 32'(sum), 32'h0002);
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_sum", 32'(sum), 32'h0);
        checkOutput("midrst_cout", 32'(cout), 32'd0);
        checkOutput("midrst_ov", 32'(out_valid), 32'd0);
        checkOutput("midrst_ir", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checkOutput("midrst_no_emit", 32'(seen), 32'd0);

        // Recovery after reset
        applyStimulus(16'h0050, 16'h0050, 1'b0, lat);
        checkOutput("sum_recover", 32'(sum), 32'h0100);
        checkOutput("lat_recover", 32'(lat), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
